// File: rtl/ctrl_pipe_pkg.sv
// Shared types and defaults for the sequencer control-bundle pipeline.
// The bundle struct is fixed at the default widths; the top packs parameterised widths itself.
package ctrl_pipe_pkg;

  localparam int NEURON_ADDR_W_DEF = 12;
  localparam int WEIGHT_ADDR_W_DEF = 16;

  typedef struct packed {
    logic                         done;
    logic [NEURON_ADDR_W_DEF-1:0] neuron_addr;
    logic [WEIGHT_ADDR_W_DEF-1:0] weight_addr;
    logic                         reset_mult_acc;
    logic [NEURON_ADDR_W_DEF-1:0] out_neuron_addr;
    logic                         write_neuron;
  } ctrl_bundle_t;

  function automatic ctrl_bundle_t zero_bundle();
    return '0;
  endfunction

  // Flat payload width for arbitrary address widths (three flags plus three addresses).
  function automatic int bundle_width(input int naw, input int waw);
    return 3 + 2 * naw + waw;
  endfunction

endpackage

// File: rtl/ctrl_pipe_stage.sv
// One valid+payload register of the control pipeline.
// An invalid stage always carries an all-zero payload, so flags never leak without valid.
module ctrl_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         en_i,
  input  logic         vld_i,
  input  logic [W-1:0] data_i,
  output logic         vld_o,
  output logic [W-1:0] data_o
);

  logic         vld_q, vld_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (flush_i) begin
      vld_d  = 1'b0;
      data_d = '0;
    end else if (en_i) begin
      vld_d  = vld_i;
      data_d = vld_i ? data_i : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;

endmodule

// File: rtl/ctrl_pipe_buffer.sv
// STAGES-deep valid/ready pipeline for the MLP sequencer control bundle, with
// bubble collapsing, synchronous flush and a registered occupancy count.
module ctrl_pipe_buffer
  import ctrl_pipe_pkg::*;
#(
  parameter int STAGES        = 2,
  parameter int NEURON_ADDR_W = NEURON_ADDR_W_DEF,
  parameter int WEIGHT_ADDR_W = WEIGHT_ADDR_W_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_done,
  input  logic                         in_reset_mult_acc,
  input  logic                         in_write_neuron,
  input  logic [NEURON_ADDR_W-1:0]     in_neuron_addr,
  input  logic [NEURON_ADDR_W-1:0]     in_out_neuron_addr,
  input  logic [WEIGHT_ADDR_W-1:0]     in_weight_addr,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_done,
  output logic                         out_reset_mult_acc,
  output logic                         out_write_neuron,
  output logic [NEURON_ADDR_W-1:0]     out_neuron_addr,
  output logic [NEURON_ADDR_W-1:0]     out_out_neuron_addr,
  output logic [WEIGHT_ADDR_W-1:0]     out_weight_addr,
  output logic [$clog2(STAGES+1)-1:0]  occupancy
);

  localparam int W     = bundle_width(NEURON_ADDR_W, WEIGHT_ADDR_W);
  localparam int OCC_W = $clog2(STAGES + 1);

  logic [W-1:0]      in_bundle;
  logic [STAGES-1:0] vld;
  logic [W-1:0]      data [STAGES];
  logic [STAGES:0]   en;
  logic              accept;
  logic              xfer;
  logic [OCC_W-1:0]  occ_q, occ_d;

  assign in_bundle = {in_done, in_neuron_addr, in_weight_addr,
                      in_reset_mult_acc, in_out_neuron_addr, in_write_neuron};

  // Ready ripples back from the output: a stage may load if it is empty or its successor moves.
  always_comb begin
    en         = '0;
    en[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      en[i] = !vld[i] || en[i+1];
    end
  end

  assign in_ready  = en[0] && !flush;
  assign accept    = in_valid && in_ready;
  assign out_valid = vld[STAGES-1];
  assign xfer      = out_valid && out_ready;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic         src_vld;
    logic [W-1:0] src_data;

    if (i == 0) begin : g_head
      assign src_vld  = accept;
      assign src_data = in_bundle;
    end else begin : g_body
      assign src_vld  = vld[i-1];
      assign src_data = data[i-1];
    end

    ctrl_pipe_stage #(.W(W)) u_stage (
      .clk     (clk),
      .rst_ni  (reset),
      .flush_i (flush),
      .en_i    (en[i]),
      .vld_i   (src_vld),
      .data_i  (src_data),
      .vld_o   (vld[i]),
      .data_o  (data[i])
    );
  end

  assign {out_done, out_neuron_addr, out_weight_addr,
          out_reset_mult_acc, out_out_neuron_addr, out_write_neuron} = data[STAGES-1];

  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (accept && !xfer) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!accept && xfer) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

endmodule

// File: tb/tb_ctrl_pipe_buffer.sv
// Scoreboard bench for ctrl_pipe_buffer: directed scenarios followed by random traffic,
// checked against a latency-aware FIFO reference model.
module tb_ctrl_pipe_buffer;
  import ctrl_pipe_pkg::*;

  localparam int S   = 2;
  localparam int NAW = NEURON_ADDR_W_DEF;
  localparam int WAW = WEIGHT_ADDR_W_DEF;

  logic           clk = 1'b0;
  logic           reset, flush, in_valid, out_ready;
  logic           in_ready, out_valid;
  logic           in_done, in_reset_mult_acc, in_write_neuron;
  logic [NAW-1:0] in_neuron_addr, in_out_neuron_addr;
  logic [WAW-1:0] in_weight_addr;
  logic           out_done, out_reset_mult_acc, out_write_neuron;
  logic [NAW-1:0] out_neuron_addr, out_out_neuron_addr;
  logic [WAW-1:0] out_weight_addr;
  logic [$clog2(S+1)-1:0] occupancy;

  ctrl_pipe_buffer #(.STAGES(S), .NEURON_ADDR_W(NAW), .WEIGHT_ADDR_W(WAW)) dut (
    .clk                (clk),
    .reset              (reset),
    .flush              (flush),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_done            (in_done),
    .in_reset_mult_acc  (in_reset_mult_acc),
    .in_write_neuron    (in_write_neuron),
    .in_neuron_addr     (in_neuron_addr),
    .in_out_neuron_addr (in_out_neuron_addr),
    .in_weight_addr     (in_weight_addr),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_done           (out_done),
    .out_reset_mult_acc (out_reset_mult_acc),
    .out_write_neuron   (out_write_neuron),
    .out_neuron_addr    (out_neuron_addr),
    .out_out_neuron_addr(out_out_neuron_addr),
    .out_weight_addr    (out_weight_addr),
    .occupancy          (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    ctrl_bundle_t b;
    int unsigned  a;
  } ent_t;

  ent_t        q[$];
  int unsigned n_edge    = 0;
  int unsigned last_dep  = 0;
  int          compared   = 0;
  int          mismatched = 0;

  always @(posedge clk) n_edge <= n_edge + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", nm, n_edge, got, exp);
    end
  endtask

  function automatic ctrl_bundle_t cur_in();
    ctrl_bundle_t b;
    b.done            = in_done;
    b.neuron_addr     = in_neuron_addr;
    b.weight_addr     = in_weight_addr;
    b.reset_mult_acc  = in_reset_mult_acc;
    b.out_neuron_addr = in_out_neuron_addr;
    b.write_neuron    = in_write_neuron;
    return b;
  endfunction

  function automatic ctrl_bundle_t cur_out();
    ctrl_bundle_t b;
    b.done            = out_done;
    b.neuron_addr     = out_neuron_addr;
    b.weight_addr     = out_weight_addr;
    b.reset_mult_acc  = out_reset_mult_acc;
    b.out_neuron_addr = out_out_neuron_addr;
    b.write_neuron    = out_write_neuron;
    return b;
  endfunction

  function automatic ctrl_bundle_t rand_b();
    ctrl_bundle_t b;
    b.done            = 1'($urandom);
    b.neuron_addr     = NAW'($urandom);
    b.weight_addr     = WAW'($urandom);
    b.reset_mult_acc  = 1'($urandom);
    b.out_neuron_addr = NAW'($urandom);
    b.write_neuron    = 1'($urandom);
    return b;
  endfunction

  task automatic put(input ctrl_bundle_t b);
    in_done            = b.done;
    in_neuron_addr     = b.neuron_addr;
    in_weight_addr     = b.weight_addr;
    in_reset_mult_acc  = b.reset_mult_acc;
    in_out_neuron_addr = b.out_neuron_addr;
    in_write_neuron    = b.write_neuron;
  endtask

  // Monitor: compare against the model, then advance the model for the coming edge.
  // The model is a FIFO where each entry reaches the output no earlier than S-1 edges
  // after acceptance and no earlier than the departure of the entry ahead of it.
  initial begin
    ctrl_bundle_t got;
    logic         exp_vis, exp_rdy, acc, xf;
    int unsigned  ready_at;
    forever begin
      @(negedge clk);
      exp_vis = 1'b0;
      if (q.size() > 0) begin
        ready_at = q[0].a + S - 1;
        if (last_dep > ready_at) ready_at = last_dep;
        exp_vis = (n_edge >= ready_at);
      end
      exp_rdy = !flush && ((q.size() < S) || out_ready);
      if (n_edge >= 1) begin
        got = cur_out();
        chk("out_valid", 64'(out_valid), 64'(exp_vis));
        chk("occupancy", 64'(occupancy), 64'(q.size()));
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        if (exp_vis) chk("payload", 64'(got), 64'(q[0].b));
        else         chk("idle_payload_zero", 64'(got), 64'(zero_bundle()));
      end
      acc = in_valid && exp_rdy;
      xf  = exp_vis && out_ready;
      if (!reset || flush) begin
        q.delete();
      end else begin
        if (xf) begin
          void'(q.pop_front());
          last_dep = n_edge + 1;
        end
        if (acc) q.push_back('{b: cur_in(), a: n_edge + 1});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input ctrl_bundle_t b);
    logic ok;
    int   n;
    in_valid = 1'b1;
    put(b);
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = in_ready;
      tick();
      n++;
    end
    if (!ok) begin
      mismatched++;
      $display("FAIL send_timeout: got no in_ready within %0d cycles, required acceptance", n);
    end
    in_valid = 1'b0;
    put(rand_b());
  endtask

  function automatic ctrl_bundle_t mk(input int unsigned wa, input logic wn);
    ctrl_bundle_t b;
    b              = rand_b();
    b.weight_addr  = WAW'(wa);
    b.write_neuron = wn;
    return b;
  endfunction

  initial begin
    logic took;
    reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; put(rand_b());
    repeat (2) tick();
    reset = 1'b1; in_valid = 1'b0;
    tick();

    // streaming at full rate
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) send(mk(i, 1'b0));
    repeat (4) tick();

    // backpressure: two fill the pipe, the third waits until the head drains
    out_ready = 1'b0;
    send(mk(16'h0011, 1'b0));
    send(mk(16'h0012, 1'b0));
    in_valid = 1'b1; put(mk(16'h0013, 1'b0));
    repeat (3) tick();
    out_ready = 1'b1;
    send(mk(16'h0013, 1'b0));
    repeat (4) tick();

    // bubble collapse under stall
    out_ready = 1'b0;
    send(mk(16'h0021, 1'b1));
    tick();
    send(mk(16'h0022, 1'b1));
    repeat (3) tick();
    out_ready = 1'b1;
    repeat (4) tick();

    // flush drops in-flight entries and the presented bundle
    out_ready = 1'b0;
    send(mk(16'h0031, 1'b1));
    send(mk(16'h0032, 1'b1));
    in_valid = 1'b1; put(mk(16'h0033, 1'b1)); flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    repeat (2) tick();

    // reset together with flush while the output is transferring
    out_ready = 1'b0;
    send(mk(16'h0041, 1'b1));
    send(mk(16'h0042, 1'b1));
    in_valid = 1'b1; put(mk(16'h0043, 1'b1));
    out_ready = 1'b1; reset = 1'b0; flush = 1'b1;
    tick();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
    repeat (3) tick();

    // random traffic with occasional flush and reset
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      took = in_valid && in_ready && reset;
      tick();
      reset     = ($urandom_range(0, 149) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if (!reset) begin
        in_valid = 1'b0;
      end else if (took || !in_valid) begin
        in_valid = ($urandom_range(0, 2) != 0);
        put(rand_b());
      end
    end
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_buffer.md
Name: ctrl_pipe_buffer

Overview:
- Parametrised successor to the fixed one-deep control-bundle register between MLP sequencer stages.
- Carries the sequencer control bundle (done, neuron_addr, weight_addr, reset_mult_acc, out_neuron_addr, write_neuron) through STAGES register stages.
- Adds valid/ready backpressure, bubble collapsing, synchronous flush and an occupancy count.
- Sits between the address sequencer and the multiply-accumulate / neuron-writeback stages.

Parameters:
- STAGES, 2, number of register stages, legal range 1..8.
- NEURON_ADDR_W, 12, width of neuron_addr and out_neuron_addr.
- WEIGHT_ADDR_W, 16, width of weight_addr.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous reset, active-low: sampled on the clk rising edge, asserted when 0.
- flush  in  1  synchronous flush; drops all in-flight entries.
- in_valid  in  1  upstream bundle valid.
- in_ready  out  1  block can accept this cycle; combinational.
- in_done, in_reset_mult_acc, in_write_neuron  in  1 each  control flags.
- in_neuron_addr, in_out_neuron_addr  in  NEURON_ADDR_W  addresses.
- in_weight_addr  in  WEIGHT_ADDR_W  weight address.
- out_valid  out  1  last stage holds a valid bundle.
- out_ready  in  1  downstream accepts this cycle.
- out_done, out_reset_mult_acc, out_write_neuron  out  1 each  flags.
- out_neuron_addr, out_out_neuron_addr  out  NEURON_ADDR_W  addresses.
- out_weight_addr  out  WEIGHT_ADDR_W  weight address.
- occupancy  out  $clog2(STAGES+1)  count of valid stages.

Behaviour:
- Stage state: stage i (0..STAGES-1) holds v[i] and a payload. Stage STAGES-1 drives the out_* ports.
- Enable chain: en[STAGES] = out_ready; en[i] = !v[i] || en[i+1]; in_ready = en[0] && !flush. The chain is combinational; no register sits on the ready path.
- Stage load: on an edge with en[i]=1, stage i loads from stage i-1 (stage 0 loads from the in_* ports qualified by in_valid && in_ready).
- Bubble clearing: when the loaded source is invalid, v[i]<=0 and the payload is <=0. A stage with en[i]=0 holds its value.
- Invariant: every out_* payload is 0 whenever out_valid=0. Flags are therefore never asserted without valid.
- Latency and throughput: with out_ready held at 1, a bundle accepted at edge k appears on the outputs after edge k+STAGES-1 (STAGES cycles from in_* to out_*). Throughput is 1 bundle per cycle.
- Bubble collapsing: an empty stage accepts even while downstream is stalled. With out_ready=0, the pipe absorbs up to STAGES bundles before in_ready drops.
- Transfer: a bundle completes when out_valid && out_ready. out_valid and the payload are held stable while out_ready=0.
- Flush: at the edge, all v<=0 and all payloads <=0. The in_* bundle presented in the flush cycle is not accepted (in_ready=0). occupancy=0 on the next cycle.
- Reset: when reset=0, the edge clears all v and payloads to 0 and gives occupancy=0, out_valid=0, all out_*=0. Reset has priority over flush and over any handshake.
  - Reset asserted mid-stream discards all in-flight bundles.
  - in_ready is combinational from state, so it reads 1 after reset. Upstream must not present in_valid while reset=0.
- Occupancy: popcount of v, registered alongside v.
  - Accept with no output transfer: +1.
  - Output transfer with no accept: -1.
  - Both in the same cycle: unchanged.
- Simultaneous full and draining: with all stages valid and out_ready=1, in_ready=1 the same cycle and the whole pipe shifts.
- STAGES=1 gives a single register with the same semantics: in_ready = !v[0] || out_ready.

Decomposition:
- Package ctrl_pipe_pkg holds:
  - NEURON_ADDR_W and WEIGHT_ADDR_W defaults.
  - A packed struct typedef ctrl_bundle_t for the six fields.
  - A function returning a zero bundle.
- Sub-module ctrl_pipe_stage: one valid+payload register with load enable, bubble clear, flush and reset. It is instantiated STAGES times in a generate loop.
- The top level owns the enable chain and the occupancy counter.

Test Plan:
- Reset: hold reset=0 for 2 cycles with in_valid=1 -> out_valid=0, all out_*=0, occupancy=0; in_ready=1 after reset releases.
- Streaming (STAGES=2): out_ready=1; send weight_addr 0x0001..0x0004 on consecutive cycles -> identical sequence at the outputs, first appearing 2 cycles after acceptance, no gaps.
- Backpressure (STAGES=2): out_ready=0; send 3 bundles -> first 2 accepted, occupancy=2, in_ready=0 on the 3rd; raise out_ready -> the 3rd is accepted in the same cycle the 1st transfers; order is preserved.
- Bubble collapse: send A, idle 1 cycle, send B with out_ready=0 -> occupancy=2, A at output with out_valid=1 and stable, B in stage 0.
- Flush: pipe holds 2 bundles with write_neuron=1 and flush=1 for one cycle while in_valid=1 -> next cycle occupancy=0, out_valid=0, out_write_neuron=0; the input bundle is dropped.
- Reset mid-operation: reset=0 in the same cycle as flush=1, with out_ready=1 and a valid output -> all cleared and no accept occurs; the 3rd bundle is discarded.
